// File: rtl/deadlock_stall_monitor.sv
// ---------------------------------------------------------------------------
// deadlock_stall_monitor
//
// Watches a set of kernel channels and declares a deadlock when every active
// channel has been stalled for TIMEOUT consecutive cycles. A channel is active
// when its instance is not idle. It is stalled when it is active and either
// its stream or its instance reports blocked. A kernel with no active channels
// is never counted as stalled.
//
// Ports
//   clock            single clock, rising-edge state updates
//   reset            synchronous active-high reset, highest priority
//   axis_block_sigs  per-channel stream blocked flags
//   inst_idle_sigs   per-channel instance idle flags
//   inst_block_sigs  per-channel instance blocked (non-stream) flags
//   clear            synchronous clear of the latched block state
//   block            deadlock declared
//   block_event      one-cycle pulse when block is entered
//   block_ch         lowest stalled channel index, captured at block entry
//   block_mask       stalled-channel vector, captured at block entry
//   stall_cnt        current consecutive all-stalled cycle count
// ---------------------------------------------------------------------------
module deadlock_stall_monitor #(
   parameter int NUM_CH  = 5,
   parameter int TIMEOUT = 1024,
   parameter int CNT_W   = 16,
   parameter int STICKY  = 1,
   parameter int IDX_W   = 3
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [NUM_CH-1:0] axis_block_sigs,
   input  logic [NUM_CH-1:0] inst_idle_sigs,
   input  logic [NUM_CH-1:0] inst_block_sigs,
   input  logic              clear,
   output logic              block,
   output logic              block_event,
   output logic [IDX_W-1:0]  block_ch,
   output logic [NUM_CH-1:0] block_mask,
   output logic [CNT_W-1:0]  stall_cnt
);

   typedef enum logic [1:0] {IDLE, COUNTING, BLOCKED} state_t;

   localparam logic [CNT_W:0]   TIMEOUT_W = (CNT_W+1)'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

   state_t             state;
   logic [NUM_CH-1:0]  active;
   logic [NUM_CH-1:0]  stalled;
   logic               all_stalled;
   logic [IDX_W-1:0]   low_idx;
   logic [CNT_W:0]     cnt_inc;
   logic               reach_timeout;

   // Per-channel classification. The all-stalled condition requires at least
   // one active channel, so a fully idle kernel is never mistaken for a hang.
   always_comb begin
      active      = ~inst_idle_sigs;
      stalled     = active & (axis_block_sigs | inst_block_sigs);
      all_stalled = (active != '0) && (stalled == active);
   end

   // Lowest set index of the stalled vector. Scanning from the top down lets
   // the last hit (the lowest index) win without a priority chain of ifs.
   always_comb begin
      low_idx = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (stalled[i]) low_idx = IDX_W'(i);
      end
   end

   // The increment is one bit wider so the timeout compare cannot be fooled
   // by a wrap of the counter.
   always_comb begin
      cnt_inc       = {1'b0, stall_cnt} + {{CNT_W{1'b0}}, 1'b1};
      reach_timeout = (cnt_inc >= TIMEOUT_W);
   end

   // Main FSM with registered outputs. Priority is reset, then clear, then
   // the normal transitions, so a clear in the same cycle as a timeout keeps
   // the monitor out of BLOCKED. block_event defaults low every cycle so it
   // can only pulse on the entry edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         block       <= 1'b0;
         block_event <= 1'b0;
         block_ch    <= '0;
         block_mask  <= '0;
         stall_cnt   <= '0;
      end else if (clear) begin
         state       <= IDLE;
         block       <= 1'b0;
         block_event <= 1'b0;
         block_ch    <= '0;
         block_mask  <= '0;
         stall_cnt   <= '0;
      end else begin
         block_event <= 1'b0;
         case (state)
            IDLE: begin
               if (all_stalled) begin
                  stall_cnt <= cnt_inc[CNT_W-1:0];
                  if (TIMEOUT == 1) begin
                     state       <= BLOCKED;
                     block       <= 1'b1;
                     block_event <= 1'b1;
                     block_mask  <= stalled;
                     block_ch    <= low_idx;
                  end else begin
                     state <= COUNTING;
                  end
               end
            end
            COUNTING: begin
               if (!all_stalled) begin
                  state     <= IDLE;
                  stall_cnt <= '0;
               end else begin
                  stall_cnt <= cnt_inc[CNT_W-1:0];
                  if (reach_timeout) begin
                     state       <= BLOCKED;
                     block       <= 1'b1;
                     block_event <= 1'b1;
                     block_mask  <= stalled;
                     block_ch    <= low_idx;
                  end
               end
            end
            BLOCKED: begin
               if (all_stalled) begin
                  if (stall_cnt != CNT_MAX) stall_cnt <= cnt_inc[CNT_W-1:0];
               end else if (STICKY == 0) begin
                  state      <= IDLE;
                  block      <= 1'b0;
                  block_mask <= '0;
                  block_ch   <= '0;
                  stall_cnt  <= '0;
               end
            end
            default: begin
               state     <= IDLE;
               block     <= 1'b0;
               stall_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_deadlock_stall_monitor.sv
// ---------------------------------------------------------------------------
// tb_deadlock_stall_monitor
//
// Directed bench for deadlock_stall_monitor with NUM_CH=5, TIMEOUT=4,
// CNT_W=16. Two instances share the stimulus: one sticky and one non-sticky.
// A vector table drives the sticky instance through counting, block entry,
// release, clear and reset. Hand-written sequences cover the all-idle case
// and the release and re-entry behaviour of the non-sticky instance.
// ---------------------------------------------------------------------------
module tb_deadlock_stall_monitor;

   logic        clock = 1'b0;
   logic        reset;
   logic [4:0]  axis_block_sigs;
   logic [4:0]  inst_idle_sigs;
   logic [4:0]  inst_block_sigs;
   logic        clear;

   logic        s_block, s_event;
   logic [2:0]  s_ch;
   logic [4:0]  s_mask;
   logic [15:0] s_cnt;

   logic        n_block, n_event;
   logic [2:0]  n_ch;
   logic [4:0]  n_mask;
   logic [15:0] n_cnt;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        rst;
      logic        clr;
      logic [4:0]  idle;
      logic [4:0]  axis;
      logic [4:0]  iblk;
      logic        e_block;
      logic        e_event;
      logic [2:0]  e_ch;
      logic [4:0]  e_mask;
      logic [15:0] e_cnt;
   } vec_t;

   vec_t vecs[$];

   deadlock_stall_monitor #(.NUM_CH(5), .TIMEOUT(4), .CNT_W(16), .STICKY(1), .IDX_W(3)) u_sticky (
      .clock(clock), .reset(reset), .axis_block_sigs(axis_block_sigs),
      .inst_idle_sigs(inst_idle_sigs), .inst_block_sigs(inst_block_sigs), .clear(clear),
      .block(s_block), .block_event(s_event), .block_ch(s_ch), .block_mask(s_mask),
      .stall_cnt(s_cnt));

   deadlock_stall_monitor #(.NUM_CH(5), .TIMEOUT(4), .CNT_W(16), .STICKY(0), .IDX_W(3)) u_nonsticky (
      .clock(clock), .reset(reset), .axis_block_sigs(axis_block_sigs),
      .inst_idle_sigs(inst_idle_sigs), .inst_block_sigs(inst_block_sigs), .clear(clear),
      .block(n_block), .block_event(n_event), .block_ch(n_ch), .block_mask(n_mask),
      .stall_cnt(n_cnt));

   always #5 clock = ~clock;

   // Drive one set of inputs, let one rising edge pass, then settle past it.
   task automatic applyStimulus(input logic rst, input logic clr, input logic [4:0] idle,
                                input logic [4:0] axis, input logic [4:0] iblk);
      reset           = rst;
      clear           = clr;
      inst_idle_sigs  = idle;
      axis_block_sigs = axis;
      inst_block_sigs = iblk;
      @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic checkSticky(input string tag, input logic b, input logic e, input logic [2:0] ch,
                              input logic [4:0] m, input logic [15:0] c);
      checkOutput({tag, " block"},       32'(s_block), 32'(b));
      checkOutput({tag, " block_event"}, 32'(s_event), 32'(e));
      checkOutput({tag, " block_ch"},    32'(s_ch),    32'(ch));
      checkOutput({tag, " block_mask"},  32'(s_mask),  32'(m));
      checkOutput({tag, " stall_cnt"},   32'(s_cnt),   32'(c));
   endtask

   task automatic checkNonSticky(input string tag, input logic b, input logic e, input logic [2:0] ch,
                                 input logic [4:0] m, input logic [15:0] c);
      checkOutput({tag, " block"},       32'(n_block), 32'(b));
      checkOutput({tag, " block_event"}, 32'(n_event), 32'(e));
      checkOutput({tag, " block_ch"},    32'(n_ch),    32'(ch));
      checkOutput({tag, " block_mask"},  32'(n_mask),  32'(m));
      checkOutput({tag, " stall_cnt"},   32'(n_cnt),   32'(c));
   endtask

   function automatic void addVec(input logic rst, input logic clr, input logic [4:0] idle,
                                  input logic [4:0] axis, input logic [4:0] iblk,
                                  input logic b, input logic e, input logic [2:0] ch,
                                  input logic [4:0] m, input logic [15:0] c);
      vec_t v;
      v.rst = rst; v.clr = clr; v.idle = idle; v.axis = axis; v.iblk = iblk;
      v.e_block = b; v.e_event = e; v.e_ch = ch; v.e_mask = m; v.e_cnt = c;
      vecs.push_back(v);
   endfunction

   // Stall pattern S: channels 1 and 3 active, both stream-blocked.
   localparam logic [4:0] S_IDLE = 5'b10101;
   localparam logic [4:0] S_AXIS = 5'b01010;

   initial begin
      // Partial activity: channel 0 active but not blocked.
      addVec(0, 0, 5'b00000, 5'b11110, 5'b00000, 0, 0, 0, 5'b00000, 0);
      // Count up to the timeout and enter BLOCKED.
      addVec(0, 0, S_IDLE, S_AXIS, 5'b00000, 0, 0, 0, 5'b00000, 1);
      addVec(0, 0, S_IDLE, S_AXIS, 5'b00000, 0, 0, 0, 5'b00000, 2);
      addVec(0, 0, S_IDLE, S_AXIS, 5'b00000, 0, 0, 0, 5'b00000, 3);
      addVec(0, 0, S_IDLE, S_AXIS, 5'b00000, 1, 1, 1, 5'b01010, 4);
      addVec(0, 0, S_IDLE, S_AXIS, 5'b00000, 1, 0, 1, 5'b01010, 5);
      // Stall released: the sticky block and the count hold.
      addVec(0, 0, 5'b11111, 5'b00000, 5'b00000, 1, 0, 1, 5'b01010, 5);
      addVec(0, 0, 5'b11111, 5'b00000, 5'b00000, 1, 0, 1, 5'b01010, 5);
      // A different full stall counts again, but the latched mask and channel are unchanged.
      addVec(0, 0, 5'b00000, 5'b00000, 5'b11111, 1, 0, 1, 5'b01010, 6);
      // Clear while the stall persists.
      addVec(0, 1, S_IDLE, S_AXIS, 5'b00000, 0, 0, 0, 5'b00000, 0);
      addVec(0, 0, S_IDLE, S_AXIS, 5'b00000, 0, 0, 0, 5'b00000, 1);
      addVec(0, 0, S_IDLE, S_AXIS, 5'b00000, 0, 0, 0, 5'b00000, 2);
      addVec(0, 0, S_IDLE, S_AXIS, 5'b00000, 0, 0, 0, 5'b00000, 3);
      // One-cycle gap on channel 3 restarts the count.
      addVec(0, 0, S_IDLE, 5'b00010, 5'b00000, 0, 0, 0, 5'b00000, 0);
      addVec(0, 0, S_IDLE, S_AXIS, 5'b00000, 0, 0, 0, 5'b00000, 1);
      addVec(0, 0, S_IDLE, S_AXIS, 5'b00000, 0, 0, 0, 5'b00000, 2);
      addVec(0, 0, S_IDLE, S_AXIS, 5'b00000, 0, 0, 0, 5'b00000, 3);
      addVec(0, 0, S_IDLE, S_AXIS, 5'b00000, 1, 1, 1, 5'b01010, 4);
      addVec(0, 0, S_IDLE, S_AXIS, 5'b00000, 1, 0, 1, 5'b01010, 5);
      addVec(0, 0, S_IDLE, S_AXIS, 5'b00000, 1, 0, 1, 5'b01010, 6);
      addVec(0, 0, S_IDLE, S_AXIS, 5'b00000, 1, 0, 1, 5'b01010, 7);
      // Reset while BLOCKED with stall_cnt 7, then block again after four edges.
      addVec(1, 0, S_IDLE, S_AXIS, 5'b00000, 0, 0, 0, 5'b00000, 0);
      addVec(0, 0, S_IDLE, S_AXIS, 5'b00000, 0, 0, 0, 5'b00000, 1);
      addVec(0, 0, S_IDLE, S_AXIS, 5'b00000, 0, 0, 0, 5'b00000, 2);
      addVec(0, 0, S_IDLE, S_AXIS, 5'b00000, 0, 0, 0, 5'b00000, 3);
      addVec(0, 0, S_IDLE, S_AXIS, 5'b00000, 1, 1, 1, 5'b01010, 4);
      addVec(0, 1, S_IDLE, S_AXIS, 5'b00000, 0, 0, 0, 5'b00000, 0);
      // Clear on the edge that would otherwise enter BLOCKED.
      addVec(0, 0, S_IDLE, S_AXIS, 5'b00000, 0, 0, 0, 5'b00000, 1);
      addVec(0, 0, S_IDLE, S_AXIS, 5'b00000, 0, 0, 0, 5'b00000, 2);
      addVec(0, 0, S_IDLE, S_AXIS, 5'b00000, 0, 0, 0, 5'b00000, 3);
      addVec(0, 1, S_IDLE, S_AXIS, 5'b00000, 0, 0, 0, 5'b00000, 0);
      addVec(0, 0, S_IDLE, S_AXIS, 5'b00000, 0, 0, 0, 5'b00000, 1);
      // Instance-blocked stall on channels 2..4: the mask and channel are captured at entry.
      addVec(0, 0, 5'b00011, 5'b00000, 5'b11100, 0, 0, 0, 5'b00000, 2);
      addVec(0, 0, 5'b00011, 5'b00000, 5'b11100, 0, 0, 0, 5'b00000, 3);
      addVec(0, 0, 5'b00011, 5'b00000, 5'b11100, 1, 1, 2, 5'b11100, 4);
      addVec(0, 0, 5'b00000, 5'b10100, 5'b01011, 1, 0, 2, 5'b11100, 5);
      addVec(1, 0, 5'b11111, 5'b00000, 5'b00000, 0, 0, 0, 5'b00000, 0);

      // Reset state.
      applyStimulus(1, 0, 5'b11111, 5'b00000, 5'b00000);
      applyStimulus(1, 0, 5'b11111, 5'b00000, 5'b00000);
      checkSticky("reset", 0, 0, 0, 5'b00000, 0);
      checkNonSticky("reset_ns", 0, 0, 0, 5'b00000, 0);

      // All channels idle with streams blocked is never a stall.
      for (int k = 0; k < 20; k++) begin
         applyStimulus(0, 0, 5'b11111, 5'b11111, 5'b00000);
         checkOutput($sformatf("all_idle[%0d] block", k), 32'(s_block), 32'd0);
         checkOutput($sformatf("all_idle[%0d] stall_cnt", k), 32'(s_cnt), 32'd0);
      end

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].rst, vecs[i].clr, vecs[i].idle, vecs[i].axis, vecs[i].iblk);
         checkSticky($sformatf("vec[%0d]", i), vecs[i].e_block, vecs[i].e_event,
                     vecs[i].e_ch, vecs[i].e_mask, vecs[i].e_cnt);
      end

      // Non-sticky: block, then release on the next edge after the stall ends.
      applyStimulus(0, 0, S_IDLE, S_AXIS, 5'b00000);
      applyStimulus(0, 0, S_IDLE, S_AXIS, 5'b00000);
      applyStimulus(0, 0, S_IDLE, S_AXIS, 5'b00000);
      checkNonSticky("ns_cnt3", 0, 0, 0, 5'b00000, 3);
      applyStimulus(0, 0, S_IDLE, S_AXIS, 5'b00000);
      checkNonSticky("ns_enter", 1, 1, 1, 5'b01010, 4);
      applyStimulus(0, 0, S_IDLE, S_AXIS, 5'b00000);
      checkNonSticky("ns_hold", 1, 0, 1, 5'b01010, 5);
      applyStimulus(0, 0, 5'b11111, 5'b00000, 5'b00000);
      checkNonSticky("ns_release", 0, 0, 0, 5'b00000, 0);
      checkSticky("sticky_during_ns_release", 1, 0, 1, 5'b01010, 5);
      applyStimulus(0, 0, S_IDLE, S_AXIS, 5'b00000);
      checkNonSticky("ns_recount1", 0, 0, 0, 5'b00000, 1);
      applyStimulus(0, 0, S_IDLE, S_AXIS, 5'b00000);
      applyStimulus(0, 0, S_IDLE, S_AXIS, 5'b00000);
      applyStimulus(0, 0, S_IDLE, S_AXIS, 5'b00000);
      checkNonSticky("ns_reenter", 1, 1, 1, 5'b01010, 4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
